// File: rtl/fifo_sc_aw.sv
// -----------------------------------------------------------------------------
// fifo_sc_aw : single-clock FIFO with independent write and read widths.
//
// Storage is kept as UNITS lanes of MIN_W bits. A write deposits RI lanes and
// a read consumes RO lanes, both little-endian (oldest lane in the low bits).
// The read side is show-ahead: a single output register is refilled whenever
// it is empty or being drained and storage holds at least RO lanes.
//
// Handshakes (both sides): a transfer happens at a rising edge of clk_i when
// valid and ready are both high. A producer/consumer holding valid (or ready)
// while the other side is low simply waits; nothing is lost or duplicated.
//
// Ports:
//   clk_i       clock, all logic on the rising edge
//   rst_i       synchronous active-high reset (pointers, level, output register)
//   flush_i     synchronous clear of contents; rd_data_o keeps its value
//   wr_valid_i  write data valid
//   wr_ready_o  room for one full write word (from registered state only)
//   wr_data_i   write data, I_WIDTH bits
//   rd_valid_o  rd_data_o holds a complete read word
//   rd_ready_i  consumer accepts rd_data_o
//   rd_data_o   registered read data, O_WIDTH bits
//   level_o     occupied MIN_W lanes, including the output register
// -----------------------------------------------------------------------------
module fifo_sc_aw #(
    parameter int I_WIDTH = 32,
    parameter int O_WIDTH = 8,
    parameter int I_DEPTH = 64,
    localparam int MIN_W  = (I_WIDTH < O_WIDTH) ? I_WIDTH : O_WIDTH,
    localparam int UNITS  = I_DEPTH * I_WIDTH / MIN_W,
    localparam int LW     = $clog2(UNITS) + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               wr_valid_i,
    output logic               wr_ready_o,
    input  logic [I_WIDTH-1:0] wr_data_i,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output logic [O_WIDTH-1:0] rd_data_o,
    output logic [LW-1:0]      level_o
);

    localparam int RI = I_WIDTH / MIN_W;
    localparam int RO = O_WIDTH / MIN_W;
    localparam int AW = $clog2(UNITS);
    localparam int PW = AW + 1;

    // Lane storage; no reset, contents are only meaningful between pointers.
    logic [MIN_W-1:0]   mem [UNITS];

    // Pointers carry an extra wrap bit so full (difference UNITS) and empty
    // (difference 0) are distinguishable.
    logic [PW-1:0]      wptr_q, wptr_d;
    logic [PW-1:0]      rptr_q, rptr_d;
    logic               valid_q, valid_d;
    logic [O_WIDTH-1:0] data_q, data_d;

    logic [PW-1:0]      stored;
    logic [PW-1:0]      level;
    logic               wr_fire;
    logic               rd_fire;
    logic               load;

    logic [AW-1:0]      wr_addr [RI];
    logic [AW-1:0]      rd_addr [RO];
    logic [O_WIDTH-1:0] rd_word;

    // Lanes still in storage (the output register's lanes are already popped).
    assign stored = wptr_q - rptr_q;
    assign level  = stored + (valid_q ? PW'(RO) : '0);

    // Space is judged on registered state only, so a same-cycle read never
    // makes room for a same-cycle write.
    assign wr_ready_o = ((PW'(UNITS) - level) >= PW'(RI));
    assign wr_fire    = wr_valid_i & wr_ready_o;
    assign rd_fire    = valid_q & rd_ready_i;
    assign load       = (~valid_q | rd_fire) & (stored >= PW'(RO));

    // Lane addresses wrap naturally in AW bits.
    for (genvar i = 0; i < RI; i++) begin : g_wr_addr
        assign wr_addr[i] = wptr_q[AW-1:0] + AW'(i);
    end

    for (genvar j = 0; j < RO; j++) begin : g_rd_addr
        assign rd_addr[j] = rptr_q[AW-1:0] + AW'(j);
        assign rd_word[j*MIN_W +: MIN_W] = mem[rd_addr[j]];
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (wr_fire) begin
            wptr_d = wptr_q + PW'(RI);
        end
        if (load) begin
            rptr_d  = rptr_q + PW'(RO);
            valid_d = 1'b1;
            data_d  = rd_word;
        end else if (rd_fire) begin
            valid_d = 1'b0;
        end
    end

    // Reset beats flush; flush beats any same-cycle handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire && !flush_i && !rst_i) begin
            for (int i = 0; i < RI; i++) begin
                mem[wr_addr[i]] <= wr_data_i[i*MIN_W +: MIN_W];
            end
        end
    end

    assign rd_valid_o = valid_q;
    assign rd_data_o  = data_q;
    assign level_o    = level;

endmodule

// File: tb/tb_fifo_sc_aw.sv
// -----------------------------------------------------------------------------
// tb_fifo_sc_aw : directed bench for fifo_sc_aw.
// Instance a: 32-bit write, 8-bit read, depth 4 (16 lanes).
// Instance b: 8-bit write, 32-bit read, depth 16 (16 lanes).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_fifo_sc_aw;

    logic clk;
    logic rst;

    logic        a_flush, a_wr_valid, a_wr_ready, a_rd_valid, a_rd_ready;
    logic [31:0] a_wr_data;
    logic [7:0]  a_rd_data;
    logic [4:0]  a_level;

    logic        b_flush, b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready;
    logic [7:0]  b_wr_data;
    logic [31:0] b_rd_data;
    logic [4:0]  b_level;

    int n_checks;
    int n_fail;

    logic [7:0] exp_q[$];

    fifo_sc_aw #(.I_WIDTH(32), .O_WIDTH(8), .I_DEPTH(4)) dut_a (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (a_flush),
        .wr_valid_i (a_wr_valid),
        .wr_ready_o (a_wr_ready),
        .wr_data_i  (a_wr_data),
        .rd_valid_o (a_rd_valid),
        .rd_ready_i (a_rd_ready),
        .rd_data_o  (a_rd_data),
        .level_o    (a_level)
    );

    fifo_sc_aw #(.I_WIDTH(8), .O_WIDTH(32), .I_DEPTH(16)) dut_b (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (b_flush),
        .wr_valid_i (b_wr_valid),
        .wr_ready_o (b_wr_ready),
        .wr_data_i  (b_wr_data),
        .rd_valid_o (b_rd_valid),
        .rd_ready_i (b_rd_ready),
        .rd_data_o  (b_rd_data),
        .level_o    (b_level)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_checks++;
        if (a_wr_ready !== 1'b1 || a_rd_valid !== 1'b0 || a_rd_data !== 8'h00 || a_level !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_a got rdy=%b vld=%b data=%h lvl=%0d exp 1 0 00 0", a_wr_ready, a_rd_valid, a_rd_data, a_level);
        end
        n_checks++;
        if (b_wr_ready !== 1'b1 || b_rd_valid !== 1'b0 || b_rd_data !== 32'h0 || b_level !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_b got rdy=%b vld=%b data=%h lvl=%0d exp 1 0 0 0", b_wr_ready, b_rd_valid, b_rd_data, b_level);
        end
    endtask

    task automatic test_wide_to_narrow();
        logic [7:0] exp_b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        a_wr_valid = 1'b1;
        a_wr_data  = 32'hDDCCBBAA;
        tick();
        a_wr_valid = 1'b0;
        n_checks++;
        if (a_rd_valid !== 1'b0 || a_level !== 5'd4) begin
            n_fail++;
            $display("FAIL t1_after_write got vld=%b lvl=%0d exp 0 4", a_rd_valid, a_level);
        end
        tick();
        n_checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 8'hAA || a_level !== 5'd4) begin
            n_fail++;
            $display("FAIL t1_latency got vld=%b data=%h lvl=%0d exp 1 aa 4", a_rd_valid, a_rd_data, a_level);
        end
        a_rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== exp_b[k]) begin
                n_fail++;
                $display("FAIL t1_read%0d got vld=%b data=%h exp 1 %h", k, a_rd_valid, a_rd_data, exp_b[k]);
            end
            tick();
        end
        a_rd_ready = 1'b0;
        n_checks++;
        if (a_rd_valid !== 1'b0 || a_level !== 5'd0) begin
            n_fail++;
            $display("FAIL t1_drained got vld=%b lvl=%0d exp 0 0", a_rd_valid, a_level);
        end
    endtask

    task automatic test_narrow_to_wide();
        logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
        b_wr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b_wr_data = bytes[k];
            tick();
        end
        b_wr_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (b_rd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL t2_partial_cycle%0d got vld=%b exp 0", k, b_rd_valid);
            end
            tick();
        end
        n_checks++;
        if (b_level !== 5'd3) begin
            n_fail++;
            $display("FAIL t2_partial_level got %0d exp 3", b_level);
        end
        b_wr_valid = 1'b1;
        b_wr_data  = 8'h44;
        tick();
        b_wr_valid = 1'b0;
        tick();
        n_checks++;
        if (b_rd_valid !== 1'b1 || b_rd_data !== 32'h44332211 || b_level !== 5'd4) begin
            n_fail++;
            $display("FAIL t2_word got vld=%b data=%h lvl=%0d exp 1 44332211 4", b_rd_valid, b_rd_data, b_level);
        end
        b_rd_ready = 1'b1;
        tick();
        b_rd_ready = 1'b0;
        n_checks++;
        if (b_rd_valid !== 1'b0 || b_level !== 5'd0) begin
            n_fail++;
            $display("FAIL t2_drained got vld=%b lvl=%0d exp 0 0", b_rd_valid, b_level);
        end
    endtask

    task automatic test_fill();
        logic [31:0] words [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
        a_wr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_wr_data = words[k];
            tick();
        end
        n_checks++;
        if (a_wr_ready !== 1'b0 || a_level !== 5'd16 || a_rd_valid !== 1'b1 || a_rd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL t3_full got rdy=%b lvl=%0d vld=%b data=%h exp 0 16 1 00", a_wr_ready, a_level, a_rd_valid, a_rd_data);
        end
        a_wr_data = 32'hDEADBEEF;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (a_wr_ready !== 1'b0 || a_level !== 5'd16) begin
                n_fail++;
                $display("FAIL t3_blocked%0d got rdy=%b lvl=%0d exp 0 16", k, a_wr_ready, a_level);
            end
        end
        a_wr_valid = 1'b0;
        a_rd_ready = 1'b1;
        tick();
        a_rd_ready = 1'b0;
        n_checks++;
        if (a_wr_ready !== 1'b0 || a_level !== 5'd15) begin
            n_fail++;
            $display("FAIL t3_one_read got rdy=%b lvl=%0d exp 0 15", a_wr_ready, a_level);
        end
        a_rd_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            n_checks++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== 8'(k)) begin
                n_fail++;
                $display("FAIL t3_read%0d got vld=%b data=%h exp 1 %h", k, a_rd_valid, a_rd_data, 8'(k));
            end
            tick();
        end
        a_rd_ready = 1'b0;
        n_checks++;
        if (a_wr_ready !== 1'b1 || a_level !== 5'd12) begin
            n_fail++;
            $display("FAIL t3_space_back got rdy=%b lvl=%0d exp 1 12", a_wr_ready, a_level);
        end
        a_rd_ready = 1'b1;
        for (int k = 4; k < 16; k++) begin
            n_checks++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== 8'(k)) begin
                n_fail++;
                $display("FAIL t3_drain%0d got vld=%b data=%h exp 1 %h", k, a_rd_valid, a_rd_data, 8'(k));
            end
            tick();
        end
        a_rd_ready = 1'b0;
        n_checks++;
        if (a_rd_valid !== 1'b0 || a_level !== 5'd0) begin
            n_fail++;
            $display("FAIL t3_empty got vld=%b lvl=%0d exp 0 0", a_rd_valid, a_level);
        end
    endtask

    task automatic test_wrap_stalls();
        int got;
        got = 0;
        exp_q.delete();
        fork
            begin : producer
                int sent;
                int guard;
                logic acc;
                sent  = 0;
                guard = 0;
                a_wr_valid = 1'b1;
                a_wr_data  = $urandom();
                while (sent < 20 && guard < 500) begin
                    acc = a_wr_ready;
                    tick();
                    guard++;
                    if (acc) begin
                        for (int b = 0; b < 4; b++) exp_q.push_back(a_wr_data[8*b +: 8]);
                        sent++;
                        a_wr_data = $urandom();
                    end
                end
                a_wr_valid = 1'b0;
            end
            begin : consumer
                int guard;
                logic stalled;
                logic [7:0] held;
                logic [7:0] exp_b;
                guard   = 0;
                stalled = 1'b0;
                held    = 8'h00;
                while (got < 80 && guard < 1000) begin
                    a_rd_ready = 1'($urandom_range(0, 1));
                    if (stalled) begin
                        n_checks++;
                        if (a_rd_valid !== 1'b1 || a_rd_data !== held) begin
                            n_fail++;
                            $display("FAIL t4_stall_stable got vld=%b data=%h exp 1 %h", a_rd_valid, a_rd_data, held);
                        end
                    end
                    if (a_rd_valid && a_rd_ready) begin
                        n_checks++;
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL t4_extra got data=%h exp nothing", a_rd_data);
                        end else begin
                            exp_b = exp_q.pop_front();
                            if (a_rd_data !== exp_b) begin
                                n_fail++;
                                $display("FAIL t4_byte%0d got %h exp %h", got, a_rd_data, exp_b);
                            end
                        end
                        got++;
                    end
                    stalled = a_rd_valid && !a_rd_ready;
                    held    = a_rd_data;
                    tick();
                    guard++;
                end
                a_rd_ready = 1'b0;
            end
        join
        n_checks++;
        if (got != 80 || exp_q.size() != 0 || a_level !== 5'd0) begin
            n_fail++;
            $display("FAIL t4_totals got bytes=%0d left=%0d lvl=%0d exp 80 0 0", got, exp_q.size(), a_level);
        end
    endtask

    task automatic test_flush();
        logic [7:0] exp_b [4] = '{8'h04, 8'h03, 8'h02, 8'h01};
        a_wr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a_wr_data = 32'h13121110 + 32'(k) * 32'h04040404;
            tick();
        end
        a_wr_valid = 1'b0;
        tick();
        n_checks++;
        if (a_level !== 5'd12 || a_rd_valid !== 1'b1 || a_rd_data !== 8'h10 || a_wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t5_pre got lvl=%0d vld=%b data=%h rdy=%b exp 12 1 10 1", a_level, a_rd_valid, a_rd_data, a_wr_ready);
        end
        a_flush    = 1'b1;
        a_wr_valid = 1'b1;
        a_wr_data  = 32'hAAAAAAAA;
        a_rd_ready = 1'b1;
        tick();
        a_flush    = 1'b0;
        a_wr_valid = 1'b0;
        a_rd_ready = 1'b0;
        n_checks++;
        if (a_level !== 5'd0 || a_rd_valid !== 1'b0 || a_wr_ready !== 1'b1 || a_rd_data !== 8'h10) begin
            n_fail++;
            $display("FAIL t5_flushed got lvl=%0d vld=%b rdy=%b data=%h exp 0 0 1 10", a_level, a_rd_valid, a_wr_ready, a_rd_data);
        end
        tick();
        tick();
        n_checks++;
        if (a_level !== 5'd0 || a_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_no_ghost got lvl=%0d vld=%b exp 0 0", a_level, a_rd_valid);
        end
        a_wr_valid = 1'b1;
        a_wr_data  = 32'h01020304;
        tick();
        a_wr_valid = 1'b0;
        tick();
        a_rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (a_rd_valid !== 1'b1 || a_rd_data !== exp_b[k]) begin
                n_fail++;
                $display("FAIL t5_read%0d got vld=%b data=%h exp 1 %h", k, a_rd_valid, a_rd_data, exp_b[k]);
            end
            tick();
        end
        a_rd_ready = 1'b0;
        n_checks++;
        if (a_level !== 5'd0 || a_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_drained got lvl=%0d vld=%b exp 0 0", a_level, a_rd_valid);
        end
    endtask

    task automatic test_reset_midstream();
        a_wr_valid = 1'b1;
        a_wr_data  = 32'h44332211;
        tick();
        a_wr_data  = 32'h88776655;
        tick();
        a_wr_valid = 1'b0;
        tick();
        a_rd_ready = 1'b1;
        tick();
        a_rd_ready = 1'b0;
        n_checks++;
        if (a_level !== 5'd7 || a_rd_valid !== 1'b1 || a_rd_data !== 8'h22) begin
            n_fail++;
            $display("FAIL t6_pre got lvl=%0d vld=%b data=%h exp 7 1 22", a_level, a_rd_valid, a_rd_data);
        end
        rst        = 1'b1;
        a_wr_valid = 1'b1;
        a_wr_data  = 32'h99999999;
        a_rd_ready = 1'b1;
        tick();
        rst        = 1'b0;
        a_wr_valid = 1'b0;
        a_rd_ready = 1'b0;
        n_checks++;
        if (a_level !== 5'd0 || a_rd_valid !== 1'b0 || a_rd_data !== 8'h00 || a_wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t6_reset got lvl=%0d vld=%b data=%h rdy=%b exp 0 0 00 1", a_level, a_rd_valid, a_rd_data, a_wr_ready);
        end
        tick();
        tick();
        n_checks++;
        if (a_level !== 5'd0 || a_rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL t6_stays_empty got lvl=%0d vld=%b exp 0 0", a_level, a_rd_valid);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        a_flush    = 1'b0;
        a_wr_valid = 1'b0;
        a_wr_data  = '0;
        a_rd_ready = 1'b0;
        b_flush    = 1'b0;
        b_wr_valid = 1'b0;
        b_wr_data  = '0;
        b_rd_ready = 1'b0;

        test_reset();
        test_wide_to_narrow();
        test_narrow_to_wide();
        test_fill();
        test_wrap_stalls();
        test_flush();
        test_reset_midstream();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sc_aw.md
Name: fifo_sc_aw

Overview:
- Single-clock FIFO with asymmetric write and read widths. It is the next generation of the team's two-port width-converting RAM.
- Adds valid/ready handshakes on both sides, full and empty tracking, an occupancy level output, a flush input and a show-ahead registered output.
- Sits between a wide producer and a narrow consumer, or the reverse, in datapath and stream-adaptation logic.

Parameters:
- I_WIDTH, 32, write-port width in bits. Power of 2, >= 8.
- O_WIDTH, 8, read-port width in bits. Power of 2, >= 8.
- I_DEPTH, 64, capacity in write-width words. Power of 2, >= 2.
- Derived MIN_W = min(I_WIDTH, O_WIDTH).
- Derived UNITS = I_DEPTH*I_WIDTH/MIN_W, the storage size in MIN_W lanes.
- Derived RI = I_WIDTH/MIN_W and RO = O_WIDTH/MIN_W, the lanes per write and per read.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- flush_i  in  1  synchronous clear of contents. Does not reset configuration.
- wr_valid_i  in  1  write data valid.
- wr_ready_o  out  1  space for one full write word.
- wr_data_i  in  I_WIDTH  write data.
- rd_valid_o  out  1  rd_data_o holds a complete read word.
- rd_ready_i  in  1  consumer accepts rd_data_o.
- rd_data_o  out  O_WIDTH  read data, registered.
- level_o  out  $clog2(UNITS)+1  occupied MIN_W lanes, including lanes held in the output register.

Behaviour:
- Reset (rst_i=1 at an edge) clears the pointers, level and output register.
  - Outputs after reset: wr_ready_o=1, rd_valid_o=0, rd_data_o=0, level_o=0.
  - Reset wins over every other input, including mid-transfer. Contents are discarded.
- flush_i=1 has the same effect as reset on pointers, level and valid. rd_data_o keeps its value. Reset has priority over flush; flush has priority over same-cycle handshakes, so both are ignored.
- Write handshake: wr_valid_i & wr_ready_o at an edge.
  - wr_ready_o = (UNITS - level_o) >= RI, computed from registered state only.
  - Space freed by a same-cycle read is not usable until the next cycle, so a full FIFO never accepts a write in the same cycle it is read.
  - wr_valid_i with wr_ready_o=0 is a no-op. The producer holds the data; nothing is lost or overwritten.
- Lane order is little-endian.
  - A wide write places bits [MIN_W-1:0] in the oldest lane.
  - A wide read returns the oldest lane in bits [MIN_W-1:0].
- Read side is show-ahead with a single output register.
  - The register loads RO lanes from storage when it is empty, or is being emptied by a handshake this cycle, and storage holds >= RO lanes.
  - rd_valid_o is high while the register holds a word.
  - rd_data_o and rd_valid_o stay stable while rd_valid_o=1 and rd_ready_i=0.
  - Read handshake: rd_valid_o & rd_ready_i.
- Latency on an empty FIFO: a write accepted at edge t makes rd_valid_o=1 after edge t+1 (two clocks from the handshake cycle), provided that write completes RO lanes.
- Back-to-back throughput: one read per cycle with rd_ready_i held high while at least RO lanes are stored. One write per cycle while space allows.
- Narrow-to-wide partial fill: fewer than RO lanes stored keeps rd_valid_o=0 indefinitely. There is no timeout or padding.
- level_o updates on the edge after each handshake.
  - Change is +RI on a write, -RO on a read, +RI-RO when both happen.
  - Never exceeds UNITS. Never underflows.
- Pointers are in MIN_W-lane units, modulo UNITS, with an extra wrap bit. Wrap-around is seamless at every ratio.
- Storage is inferred RAM with one write port and one read port. The write port is RI lanes wide at a lane-aligned address; the read port is RO lanes wide.
- When RI=RO=1, the block is a plain synchronous FIFO of depth I_DEPTH.

Test Plan:
1. I_WIDTH=32, O_WIDTH=8, I_DEPTH=4. Write 0xDDCCBBAA with rd_ready_i=0.
   - Response: rd_valid_o rises two clocks after the handshake; rd_data_o=0xAA; level_o=4.
   - Then hold rd_ready_i=1: reads 0xAA, 0xBB, 0xCC, 0xDD on consecutive cycles, then rd_valid_o=0 and level_o=0.
2. I_WIDTH=8, O_WIDTH=32. Write 0x11, 0x22, 0x33.
   - rd_valid_o stays 0 for 10 cycles.
   - Write 0x44: rd_data_o=0x44332211, rd_valid_o=1.
3. Fill test: 32->8, I_DEPTH=4. Write 4 words with no reads.
   - wr_ready_o=0 and level_o=16. A 5th wr_valid_i held for 5 cycles is not accepted.
   - Read one byte: wr_ready_o stays 0 (level 15 < space needed). After 4 reads, wr_ready_o=1 on the next cycle.
4. Wrap-around: 32->8, I_DEPTH=4, writing and reading continuously for 20 words with random rd_ready_i stalls.
   - Output byte stream equals the input in little-endian order with no loss or duplication.
   - rd_data_o is stable during every stall.
5. Flush: 3 words stored and rd_valid_o=1. Assert flush_i together with a write and a read handshake.
   - Next cycle: level_o=0, rd_valid_o=0, wr_ready_o=1, and the concurrent write is not stored.
   - A subsequent write of 0x01020304 reads 0x04 first.
6. Reset mid-stream at level 7: after the reset edge, level_o=0, rd_valid_o=0, rd_data_o=0, wr_ready_o=1.
